// File: rtl/text_dma_sched.sv
// Per-line glyph fetch sequencer: greeting ROM code point -> font ROM row -> one-hot sprite strobe.
// Define TEXT_DMA_STATS_EN to enable the saturating count of starts dropped while a sequence runs.
module text_dma_sched #(
  parameter int SPR_CNT      = 8,
  parameter int GREET_MSGS   = 32,
  parameter int GREET_LENGTH = 16,
  parameter int CPW          = 7,
  parameter int CP_START     = 'h20,
  parameter int FONT_GLYPHS  = 64,
  parameter int FONT_HEIGHT  = 8,
  parameter int FONT_WIDTH   = 8,
  localparam int MSG_W   = $clog2(GREET_MSGS),
  localparam int LINE_W  = $clog2(FONT_HEIGHT),
  localparam int TXT_AW  = $clog2(GREET_MSGS * GREET_LENGTH),
  localparam int FONT_AW = $clog2(FONT_GLYPHS * FONT_HEIGHT),
  localparam int IDX_W   = (SPR_CNT > 1) ? $clog2(SPR_CNT) : 1
) (
  input  logic                       video_clk_pix,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [MSG_W-1:0]           msg_sel,
  input  logic                       half,
  input  logic [SPR_CNT*LINE_W-1:0]  glyph_line,
  output logic [TXT_AW-1:0]          txt_addr,
  input  logic [CPW-1:0]             txt_data,
  output logic [FONT_AW-1:0]         font_addr,
  input  logic [FONT_WIDTH-1:0]      font_data,
  output logic [FONT_WIDTH-1:0]      spr_data,
  output logic [SPR_CNT-1:0]         spr_dma,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 overrun_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPR_CNT - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [TXT_AW-1:0]       txt_addr_q, txt_addr_d;
  logic [FONT_AW-1:0]      font_addr_q, font_addr_d;
  logic                    vld_a_q, vld_a_d, vld_f_q, vld_f_d, vld_b_q, vld_b_d;
  logic [IDX_W-1:0]        idx_a_q, idx_a_d, idx_f_q, idx_f_d, idx_b_q, idx_b_d;
  logic [FONT_WIDTH-1:0]   spr_data_q, spr_data_d;
  logic [SPR_CNT-1:0]      spr_dma_q, spr_dma_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic [LINE_W-1:0]       gl_sel;
  int                      cp_val, glyph_idx;

  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    txt_addr_d  = txt_addr_q;
    font_addr_d = font_addr_q;
    spr_dma_d   = '0;
    spr_data_d  = '0;

    unique case (state_q)
      IDLE: if (start) begin
        state_d    = FETCH;
        cnt_d      = '0;
        txt_addr_d = TXT_AW'(int'(msg_sel) * GREET_LENGTH + (half ? GREET_LENGTH / 2 : 0));
      end
      FETCH: if (cnt_q == LAST_IDX) begin
        state_d = DRAIN;
      end else begin
        cnt_d      = cnt_q + IDX_W'(1);
        txt_addr_d = txt_addr_q + TXT_AW'(1);
      end
      DRAIN: if (vld_b_q && idx_b_q == LAST_IDX) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Stage a: code point is on txt_data; translate it to a font row address.
    vld_a_d   = (state_q == FETCH);
    idx_a_d   = cnt_q;
    gl_sel    = glyph_line[int'(idx_a_q) * LINE_W +: LINE_W];
    cp_val    = int'(txt_data);
    glyph_idx = (cp_val >= CP_START && cp_val < CP_START + FONT_GLYPHS) ? cp_val - CP_START : 0;
    if (vld_a_q) font_addr_d = FONT_AW'(glyph_idx * FONT_HEIGHT + int'(gl_sel));

    vld_f_d = vld_a_q;
    idx_f_d = idx_a_q;
    vld_b_d = vld_f_q;
    idx_b_d = idx_f_q;

    // Stage b: glyph row is on font_data; hand it to the sprite it belongs to.
    if (vld_b_q) begin
      spr_dma_d[idx_b_q] = 1'b1;
      spr_data_d         = font_data;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge video_clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      txt_addr_q  <= '0;
      font_addr_q <= '0;
      vld_a_q     <= 1'b0;
      vld_f_q     <= 1'b0;
      vld_b_q     <= 1'b0;
      idx_a_q     <= '0;
      idx_f_q     <= '0;
      idx_b_q     <= '0;
      spr_data_q  <= '0;
      spr_dma_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      txt_addr_q  <= txt_addr_d;
      font_addr_q <= font_addr_d;
      vld_a_q     <= vld_a_d;
      vld_f_q     <= vld_f_d;
      vld_b_q     <= vld_b_d;
      idx_a_q     <= idx_a_d;
      idx_f_q     <= idx_f_d;
      idx_b_q     <= idx_b_d;
      spr_data_q  <= spr_data_d;
      spr_dma_q   <= spr_dma_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef TEXT_DMA_STATS_EN
  logic [7:0] overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (start && state_q != IDLE && overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
  end

  always_ff @(posedge video_clk_pix or negedge rst_n) begin
    if (!rst_n) overrun_q <= '0;
    else        overrun_q <= overrun_d;
  end

  assign overrun_cnt = overrun_q;
`else
  assign overrun_cnt = '0;
`endif

  assign txt_addr  = txt_addr_q;
  assign font_addr = font_addr_q;
  assign spr_data  = spr_data_q;
  assign spr_dma   = spr_dma_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_text_dma_sched.sv
// Bench for text_dma_sched: directed tables, corner sequences and random runs against a cycle-table model.
// Expected overrun counts follow TEXT_DMA_STATS_EN when the bench is built with it.
module tb_text_dma_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  msg_sel;
  logic        half;
  logic [23:0] glyph_line;
  logic [8:0]  txt_addr;
  logic [6:0]  txt_data = '0;
  logic [8:0]  font_addr;
  logic [7:0]  font_data = '0;
  logic [7:0]  spr_data;
  logic [7:0]  spr_dma;
  logic        busy, done;
  logic [7:0]  overrun_cnt;

  logic [6:0]  greet_rom [512];
  logic [7:0]  font_rom  [512];
  logic [8:0]  fa_seen   [8];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ovr = 0;

  typedef struct { int msg; bit hf; int exp_base; } seq_vec_t;
  typedef struct { logic [6:0] cp; logic [2:0] gl; logic [8:0] exp_fa; } font_vec_t;

  seq_vec_t  seq_tbl  [5];
  font_vec_t font_tbl [8];

  text_dma_sched dut (
    .video_clk_pix (clk),
    .rst_n         (rst_n),
    .start         (start),
    .msg_sel       (msg_sel),
    .half          (half),
    .glyph_line    (glyph_line),
    .txt_addr      (txt_addr),
    .txt_data      (txt_data),
    .font_addr     (font_addr),
    .font_data     (font_data),
    .spr_data      (spr_data),
    .spr_dma       (spr_dma),
    .busy          (busy),
    .done          (done),
    .overrun_cnt   (overrun_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous ROMs: data one cycle after address.
  always @(posedge clk) begin
    txt_data  <= greet_rom[txt_addr];
    font_data <= font_rom[font_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] model_fa(input logic [6:0] cp, input logic [2:0] gl);
    int g;
    g = (int'(cp) >= 32 && int'(cp) < 32 + 64) ? int'(cp) - 32 : 0;
    return 9'(g * 8 + int'(gl));
  endfunction

  function automatic int ovr_expect();
`ifdef TEXT_DMA_STATS_EN
    return exp_ovr;
`else
    return 0;
`endif
  endfunction

  task automatic bump_ovr();
    if (exp_ovr < 255) exp_ovr++;
  endtask

  // Entered just after a negedge; drives start for cycle T=0 and checks T+1..T+13.
  // extra_c in 1..12 re-asserts start in that cycle; rst_c > 0 pulls reset after that cycle's checks.
  task automatic run_seq(input int msg, input bit hf, input logic [23:0] gl, input int base,
                         input int extra_c, input int rst_c, input string tag);
    logic [8:0] fa [8];
    int k;
    for (int i = 0; i < 8; i++) fa[i] = model_fa(greet_rom[base + i], gl[i*3 +: 3]);
    msg_sel    = 5'(msg);
    half       = hf;
    glyph_line = gl;
    start      = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      check($sformatf("%s txt_addr c%0d", tag, c), 32'(txt_addr), 32'((c <= 8) ? base + c - 1 : base + 7));
      check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(c <= 12));
      check($sformatf("%s done c%0d", tag, c), 32'(done), 32'(c == 13));
      k = c - 5;
      if (k >= 0 && k < 8) begin
        check($sformatf("%s spr_dma c%0d", tag, c), 32'(spr_dma), 32'(1) << k);
        check($sformatf("%s spr_data c%0d", tag, c), 32'(spr_data), 32'(font_rom[fa[k]]));
      end else begin
        check($sformatf("%s spr_dma idle c%0d", tag, c), 32'(spr_dma), 32'(0));
        check($sformatf("%s spr_data idle c%0d", tag, c), 32'(spr_data), 32'(0));
      end
      if (c >= 3 && c <= 10) begin
        fa_seen[c-3] = font_addr;
        check($sformatf("%s font_addr c%0d", tag, c), 32'(font_addr), 32'(fa[c-3]));
      end
      if (c == 13) check($sformatf("%s overrun", tag), 32'(overrun_cnt), 32'(ovr_expect()));
      if (c == rst_c) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check($sformatf("%s rst spr_dma", tag), 32'(spr_dma), 32'(0));
        check($sformatf("%s rst spr_data", tag), 32'(spr_data), 32'(0));
        check($sformatf("%s rst busy", tag), 32'(busy), 32'(0));
        check($sformatf("%s rst txt_addr", tag), 32'(txt_addr), 32'(0));
        check($sformatf("%s rst font_addr", tag), 32'(font_addr), 32'(0));
        check($sformatf("%s rst overrun", tag), 32'(overrun_cnt), 32'(0));
        exp_ovr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int w = 0; w < 14; w++) begin
          @(negedge clk);
          check($sformatf("%s post-rst done w%0d", tag, w), 32'(done), 32'(0));
          check($sformatf("%s post-rst busy w%0d", tag, w), 32'(busy), 32'(0));
        end
        return;
      end
      start = (c == extra_c) && (c <= 12);
      if (start) bump_ovr();
    end
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int m, base, ex, w;
    bit hf;
    logic [23:0] gl;

    seq_tbl[0] = '{2, 1'b0, 32};
    seq_tbl[1] = '{31, 1'b1, 504};
    seq_tbl[2] = '{0, 1'b0, 0};
    seq_tbl[3] = '{0, 1'b1, 8};
    seq_tbl[4] = '{17, 1'b1, 280};

    font_tbl[0] = '{7'h41, 3'd3, 9'd267};
    font_tbl[1] = '{7'h7F, 3'd5, 9'd5};
    font_tbl[2] = '{7'h20, 3'd0, 9'd0};
    font_tbl[3] = '{7'h5F, 3'd7, 9'd511};
    font_tbl[4] = '{7'h1F, 3'd2, 9'd2};
    font_tbl[5] = '{7'h60, 3'd4, 9'd4};
    font_tbl[6] = '{7'h00, 3'd1, 9'd1};
    font_tbl[7] = '{7'h30, 3'd6, 9'd134};

    for (int i = 0; i < 512; i++) begin
      greet_rom[i] = 7'($urandom());
      font_rom[i]  = 8'($urandom());
    end

    rst_n = 1'b0; start = 1'b0; msg_sel = '0; half = 1'b0; glyph_line = '0;
    @(negedge clk);
    check("reset spr_dma", 32'(spr_dma), 32'(0));
    check("reset spr_data", 32'(spr_data), 32'(0));
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset txt_addr", 32'(txt_addr), 32'(0));
    check("reset font_addr", 32'(font_addr), 32'(0));
    check("reset overrun", 32'(overrun_cnt), 32'(0));
    rst_n = 1'b1;

    foreach (seq_tbl[i]) begin
      @(negedge clk);
      run_seq(seq_tbl[i].msg, seq_tbl[i].hf, 24'($urandom()), seq_tbl[i].exp_base, 0, 0,
              $sformatf("tbl%0d", i));
    end

    // Back-to-back: second start lands in the done cycle and must be accepted.
    @(negedge clk);
    run_seq(3, 1'b0, 24'($urandom()), 48, 0, 0, "b2b_a");
    run_seq(4, 1'b1, 24'($urandom()), 72, 0, 0, "b2b_b");

    // Starts while busy, including the final busy cycle, are dropped.
    @(negedge clk);
    run_seq(9, 1'b0, 24'($urandom()), 144, 3, 0, "ovr_c3");
    @(negedge clk);
    run_seq(10, 1'b1, 24'($urandom()), 168, 12, 0, "ovr_c12");

    // Code point translation table, including both out-of-range sides.
    gl = '0;
    foreach (font_tbl[i]) begin
      greet_rom[80 + i] = font_tbl[i].cp;
      gl[i*3 +: 3]      = font_tbl[i].gl;
    end
    @(negedge clk);
    run_seq(5, 1'b0, gl, 80, 0, 0, "font");
    foreach (font_tbl[i])
      check($sformatf("font_tbl%0d cp=%0h", i, font_tbl[i].cp), 32'(fa_seen[i]), 32'(font_tbl[i].exp_fa));

    // Reset mid-sequence, then a clean full sequence.
    @(negedge clk);
    run_seq(6, 1'b1, 24'($urandom()), 104, 2, 4, "rst_mid");
    @(negedge clk);
    run_seq(7, 1'b0, 24'($urandom()), 112, 0, 0, "post_rst");

    for (int r = 0; r < 30; r++) begin
      m    = int'($urandom_range(0, 31));
      hf   = 1'($urandom_range(0, 1));
      base = m * 16 + (hf ? 8 : 0);
      ex   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 12)) : 0;
      if ($urandom_range(0, 2) != 0) @(negedge clk);
      run_seq(m, hf, 24'($urandom()), base, ex, 0, $sformatf("rnd%0d", r));
    end

    // Hold start for 330 cycles: one accept every 13 cycles, every other cycle is an overrun.
    @(negedge clk);
    msg_sel = 5'd1; half = 1'b0; glyph_line = 24'($urandom());
    start = 1'b1;
    for (int i = 0; i < 330; i++) begin
      if (i % 13 != 0) bump_ovr();
      @(negedge clk);
    end
    start = 1'b0;
    check("hold overrun", 32'(overrun_cnt), 32'(ovr_expect()));
    w = 0;
    while (!done && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("hold drain done", 32'(done), 32'(1));
    @(negedge clk);
    check("hold idle busy", 32'(busy), 32'(0));
    check("hold overrun kept", 32'(overrun_cnt), 32'(ovr_expect()));

    rst_n = 1'b0;
    #1;
    exp_ovr = 0;
    check("final reset overrun", 32'(overrun_cnt), 32'(0));
    check("final reset busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
